p_reg_pattern_detect: RTL and testbench



---
 rtl/dsp48_pkg.sv | 22 ++
 rtl/dff.sv | 20 ++
 rtl/p_reg_pattern_detect.sv | 139 +++++++++++++
 tb/tb_p_reg_pattern_detect.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp48_pkg.sv
// Shared width constants and attribute encodings for the DSP48 slice output stage.
package dsp48_pkg;

  localparam int unsigned P_W     = 48;
  localparam int unsigned CARRY_W = 4;

  localparam string PATDET_ON  = "PATDET";
  localparam string PATDET_OFF = "NO_PATDET";

  localparam string SEL_PATTERN_PARAM = "PATTERN";
  localparam string SEL_PATTERN_C     = "C";

  localparam string SEL_MASK_MASK = "MASK";
  localparam string SEL_MASK_C    = "C";
  localparam string SEL_MASK_RND1 = "ROUNDING_MODE1";
  localparam string SEL_MASK_RND2 = "ROUNDING_MODE2";

  localparam string AUTORESET_NONE      = "NO_RESET";
  localparam string AUTORESET_MATCH     = "RESET_MATCH";
  localparam string AUTORESET_NOT_MATCH = "RESET_NOT_MATCH";

endpackage

// File: rtl/dff.sv
// Generic register cell: synchronous active-high reset dominating clock enable.
module dff #(
  parameter int unsigned signal_width = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [signal_width-1:0] in,
  input  logic                    ce,
  output logic [signal_width-1:0] out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (ce) begin
      out <= in;
    end
  end

endmodule

// File: rtl/p_reg_pattern_detect.sv
// DSP48 P output stage: P/CARRYOUT registers, pattern detect, over/underflow
// flags and pattern-driven auto-reset.
module p_reg_pattern_detect
  import dsp48_pkg::*;
#(
  parameter int unsigned     PREG               = 1,
  parameter string           USE_PATTERN_DETECT = PATDET_OFF,
  parameter logic [P_W-1:0]  PATTERN            = '0,
  parameter logic [P_W-1:0]  MASK               = 48'h3FFF_FFFF_FFFF,
  parameter string           SEL_PATTERN        = SEL_PATTERN_PARAM,
  parameter string           SEL_MASK           = SEL_MASK_MASK,
  parameter string           AUTORESET_PATDET   = AUTORESET_NONE
) (
  input  logic               clk,
  input  logic               RSTP,
  input  logic               CEP,
  input  logic [P_W-1:0]     alu_out,
  input  logic [CARRY_W-1:0] alu_carry,
  input  logic [P_W-1:0]     C,
  output logic [P_W-1:0]     P,
  output logic [P_W-1:0]     PCOUT,
  output logic [CARRY_W-1:0] CARRYOUT,
  output logic               PATTERNDETECT,
  output logic               PATTERNBDETECT,
  output logic               OVERFLOW,
  output logic               UNDERFLOW
);

  localparam bit PATDET_EN = (USE_PATTERN_DETECT == PATDET_ON);

  // Mask bit set means that bit is ignored in the compare.
  function automatic logic detect(input logic [P_W-1:0] val,
                                  input logic [P_W-1:0] pat_v,
                                  input logic [P_W-1:0] msk_v);
    return &(~(val ^ pat_v) | msk_v);
  endfunction

  logic [P_W-1:0]     pat;
  logic [P_W-1:0]     msk;
  logic               pd_c;
  logic               pbd_c;
  logic [P_W-1:0]     p_int;
  logic [CARRY_W-1:0] carry_int;
  logic [1:0]         flags;
  logic [1:0]         flags_past;
  logic               pd;
  logic               pbd;
  logic               pd_past;
  logic               pbd_past;
  logic               unused_c;

  // C only feeds pattern/mask in some configurations.
  assign unused_c = ^C;

  if (SEL_PATTERN == SEL_PATTERN_C) begin : g_pat_c
    assign pat = C;
  end else begin : g_pat_param
    assign pat = PATTERN;
  end

  if (SEL_MASK == SEL_MASK_C) begin : g_msk_c
    assign msk = C;
  end else if (SEL_MASK == SEL_MASK_RND1) begin : g_msk_rnd1
    assign msk = (~C) << 1;
  end else if (SEL_MASK == SEL_MASK_RND2) begin : g_msk_rnd2
    assign msk = (~C) << 2;
  end else begin : g_msk_param
    assign msk = MASK;
  end

  assign pd_c  = detect(alu_out, pat, msk);
  assign pbd_c = detect(alu_out, ~pat, msk);

  assign pd       = flags[1];
  assign pbd      = flags[0];
  assign pd_past  = flags_past[1];
  assign pbd_past = flags_past[0];

  if (PREG == 1) begin : g_preg
    logic autoreset;
    logic ar_rst;

    if (AUTORESET_PATDET == AUTORESET_MATCH) begin : g_ar_match
      assign autoreset = pd;
    end else if (AUTORESET_PATDET == AUTORESET_NOT_MATCH) begin : g_ar_not_match
      assign autoreset = pd_past & ~pd;
    end else begin : g_ar_none
      assign autoreset = 1'b0;
    end

    // Auto-reset clears the result registers but not the past-flag history.
    assign ar_rst = RSTP | (CEP & autoreset);

    dff #(.signal_width(P_W)) u_p (
      .clk (clk),
      .rst (ar_rst),
      .in  (alu_out),
      .ce  (CEP),
      .out (p_int)
    );

    dff #(.signal_width(CARRY_W)) u_carry (
      .clk (clk),
      .rst (ar_rst),
      .in  (alu_carry),
      .ce  (CEP),
      .out (carry_int)
    );

    dff #(.signal_width(2)) u_flags (
      .clk (clk),
      .rst (ar_rst),
      .in  ({pd_c, pbd_c}),
      .ce  (CEP),
      .out (flags)
    );
  end else begin : g_comb
    assign p_int     = alu_out;
    assign carry_int = alu_carry;
    assign flags     = {pd_c, pbd_c};
  end

  dff #(.signal_width(2)) u_past (
    .clk (clk),
    .rst (RSTP),
    .in  (flags),
    .ce  (CEP),
    .out (flags_past)
  );

  assign P              = p_int;
  assign PCOUT          = p_int;
  assign CARRYOUT       = carry_int;
  assign PATTERNDETECT  = PATDET_EN & pd;
  assign PATTERNBDETECT = PATDET_EN & pbd;
  assign OVERFLOW       = PATDET_EN & pd_past & ~pd & ~pbd;
  assign UNDERFLOW      = PATDET_EN & pbd_past & ~pd & ~pbd;

endmodule

// File: tb/tb_p_reg_pattern_detect.sv
// Scoreboard bench: six differently configured P stages share stimulus and are
// checked every cycle against a behavioural model of the output stage.
module tb_p_reg_pattern_detect;

  localparam int NI = 6;

  typedef struct {
    int          preg;
    bit          patdet;
    logic [47:0] pattern;
    logic [47:0] mask;
    bit          pat_c;
    int          msel;   // 0 MASK, 1 C, 2 ~C<<1, 3 ~C<<2
    int          ar;     // 0 none, 1 on match, 2 on match falling
  } cfg_t;

  typedef struct packed {
    logic [47:0] p;
    logic [47:0] pc;
    logic [3:0]  cy;
    logic        pd;
    logic        pbd;
    logic        ov;
    logic        un;
  } obs_t;

  typedef obs_t [NI-1:0] obs_row_t;

  logic        clk = 1'b0;
  logic        rstp = 1'b1;
  logic        cep = 1'b0;
  logic [47:0] alu = 48'h1234;
  logic [47:0] alu_b;
  logic [3:0]  carry = 4'h0;
  logic [47:0] c_in = 48'h0;

  logic [47:0] p_o   [NI];
  logic [47:0] pc_o  [NI];
  logic [3:0]  cy_o  [NI];
  logic        pd_o  [NI];
  logic        pbd_o [NI];
  logic        ov_o  [NI];
  logic        un_o  [NI];

  cfg_t        cfg   [NI];
  logic [47:0] m_p   [NI];
  logic [3:0]  m_cy  [NI];
  bit          m_pd  [NI];
  bit          m_pbd [NI];
  bit          m_pdp [NI];
  bit          m_pbdp[NI];

  obs_row_t exp_q[$];
  bit       stim_done = 1'b0;
  int       total = 0;
  int       bad = 0;

  always #5 clk = ~clk;

  // Instance 1 counts: its ALU result is always P+1.
  assign alu_b = p_o[1] + 48'd1;

  p_reg_pattern_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
    .MASK(48'hFFFF_FFFF_FF00), .SEL_PATTERN("PATTERN"), .SEL_MASK("MASK"),
    .AUTORESET_PATDET("NO_RESET")) u_a (
    .clk(clk), .RSTP(rstp), .CEP(cep), .alu_out(alu), .alu_carry(carry), .C(c_in),
    .P(p_o[0]), .PCOUT(pc_o[0]), .CARRYOUT(cy_o[0]), .PATTERNDETECT(pd_o[0]),
    .PATTERNBDETECT(pbd_o[0]), .OVERFLOW(ov_o[0]), .UNDERFLOW(un_o[0]));

  p_reg_pattern_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h5),
    .MASK(48'h0), .SEL_PATTERN("PATTERN"), .SEL_MASK("MASK"),
    .AUTORESET_PATDET("RESET_MATCH")) u_b (
    .clk(clk), .RSTP(rstp), .CEP(cep), .alu_out(alu_b), .alu_carry(carry), .C(c_in),
    .P(p_o[1]), .PCOUT(pc_o[1]), .CARRYOUT(cy_o[1]), .PATTERNDETECT(pd_o[1]),
    .PATTERNBDETECT(pbd_o[1]), .OVERFLOW(ov_o[1]), .UNDERFLOW(un_o[1]));

  p_reg_pattern_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
    .MASK(48'h3FFF_FFFF_FFFF), .SEL_PATTERN("PATTERN"), .SEL_MASK("MASK"),
    .AUTORESET_PATDET("NO_RESET")) u_c (
    .clk(clk), .RSTP(rstp), .CEP(cep), .alu_out(alu), .alu_carry(carry), .C(c_in),
    .P(p_o[2]), .PCOUT(pc_o[2]), .CARRYOUT(cy_o[2]), .PATTERNDETECT(pd_o[2]),
    .PATTERNBDETECT(pbd_o[2]), .OVERFLOW(ov_o[2]), .UNDERFLOW(un_o[2]));

  p_reg_pattern_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
    .MASK(48'h0), .SEL_PATTERN("PATTERN"), .SEL_MASK("ROUNDING_MODE1"),
    .AUTORESET_PATDET("RESET_NOT_MATCH")) u_d (
    .clk(clk), .RSTP(rstp), .CEP(cep), .alu_out(alu), .alu_carry(carry), .C(c_in),
    .P(p_o[3]), .PCOUT(pc_o[3]), .CARRYOUT(cy_o[3]), .PATTERNDETECT(pd_o[3]),
    .PATTERNBDETECT(pbd_o[3]), .OVERFLOW(ov_o[3]), .UNDERFLOW(un_o[3]));

  p_reg_pattern_detect #(.PREG(0), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
    .MASK(48'h0), .SEL_PATTERN("C"), .SEL_MASK("C"),
    .AUTORESET_PATDET("RESET_MATCH")) u_e (
    .clk(clk), .RSTP(rstp), .CEP(cep), .alu_out(alu), .alu_carry(carry), .C(c_in),
    .P(p_o[4]), .PCOUT(pc_o[4]), .CARRYOUT(cy_o[4]), .PATTERNDETECT(pd_o[4]),
    .PATTERNBDETECT(pbd_o[4]), .OVERFLOW(ov_o[4]), .UNDERFLOW(un_o[4]));

  p_reg_pattern_detect #(.PREG(1), .USE_PATTERN_DETECT("NO_PATDET"), .PATTERN(48'h0),
    .MASK(48'h0), .SEL_PATTERN("C"), .SEL_MASK("ROUNDING_MODE2"),
    .AUTORESET_PATDET("NO_RESET")) u_f (
    .clk(clk), .RSTP(rstp), .CEP(cep), .alu_out(alu), .alu_carry(carry), .C(c_in),
    .P(p_o[5]), .PCOUT(pc_o[5]), .CARRYOUT(cy_o[5]), .PATTERNDETECT(pd_o[5]),
    .PATTERNBDETECT(pbd_o[5]), .OVERFLOW(ov_o[5]), .UNDERFLOW(un_o[5]));

  // ---------------- reference model ----------------
  function automatic bit match(input logic [47:0] v, input logic [47:0] pt,
                               input logic [47:0] mk);
    for (int i = 0; i < 48; i++) begin
      if (!mk[i] && (v[i] != pt[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [47:0] pat_of(input int k, input logic [47:0] c);
    return cfg[k].pat_c ? c : cfg[k].pattern;
  endfunction

  function automatic logic [47:0] mask_of(input int k, input logic [47:0] c);
    case (cfg[k].msel)
      1:       return c;
      2:       return 48'((~c) * 48'd2);
      3:       return 48'((~c) * 48'd4);
      default: return cfg[k].mask;
    endcase
  endfunction

  function automatic void step(input int k, input logic [47:0] a, input logic [3:0] cy,
                               input logic [47:0] c, input logic r, input logic e);
    bit pdc, pbdc, fire;
    pdc  = match(a, pat_of(k, c), mask_of(k, c));
    pbdc = match(a, ~pat_of(k, c), mask_of(k, c));
    if (r) begin
      m_p[k] = '0; m_cy[k] = '0; m_pd[k] = 0; m_pbd[k] = 0; m_pdp[k] = 0; m_pbdp[k] = 0;
    end else if (e) begin
      if (cfg[k].preg == 1) begin
        fire = (cfg[k].ar == 1 && m_pd[k]) || (cfg[k].ar == 2 && m_pdp[k] && !m_pd[k]);
        m_pdp[k]  = m_pd[k];
        m_pbdp[k] = m_pbd[k];
        if (fire) begin
          m_p[k] = '0; m_cy[k] = '0; m_pd[k] = 0; m_pbd[k] = 0;
        end else begin
          m_p[k] = a; m_cy[k] = cy; m_pd[k] = pdc; m_pbd[k] = pbdc;
        end
      end else begin
        m_pdp[k]  = pdc;
        m_pbdp[k] = pbdc;
      end
    end
  endfunction

  function automatic obs_t expect_out(input int k, input logic [47:0] a,
                                      input logic [3:0] cy, input logic [47:0] c);
    obs_t o;
    bit pd, pbd;
    if (cfg[k].preg == 1) begin
      o.p = m_p[k]; o.cy = m_cy[k]; pd = m_pd[k]; pbd = m_pbd[k];
    end else begin
      o.p = a; o.cy = cy;
      pd  = match(a, pat_of(k, c), mask_of(k, c));
      pbd = match(a, ~pat_of(k, c), mask_of(k, c));
    end
    o.pc = o.p;
    if (cfg[k].patdet) begin
      o.pd = pd; o.pbd = pbd;
      o.ov = m_pdp[k] && !pd && !pbd;
      o.un = m_pbdp[k] && !pd && !pbd;
    end else begin
      o.pd = 0; o.pbd = 0; o.ov = 0; o.un = 0;
    end
    return o;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic e, input logic [47:0] a,
                       input logic [3:0] cy, input logic [47:0] c);
    obs_row_t row;
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      step(k, (k == 1) ? m_p[1] + 48'd1 : alu, carry, c_in, rstp, cep);
    end
    #1;
    rstp = r; cep = e; alu = a; carry = cy; c_in = c;
    for (int k = 0; k < NI; k++) begin
      row[k] = expect_out(k, (k == 1) ? m_p[1] + 48'd1 : a, cy, c);
    end
    exp_q.push_back(row);
  endtask

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic [47:0] a, c;
    cfg[0] = '{1, 1, 48'h0, 48'hFFFF_FFFF_FF00, 0, 0, 0};
    cfg[1] = '{1, 1, 48'h5, 48'h0, 0, 0, 1};
    cfg[2] = '{1, 1, 48'h0, 48'h3FFF_FFFF_FFFF, 0, 0, 0};
    cfg[3] = '{1, 1, 48'h0, 48'h0, 0, 2, 2};
    cfg[4] = '{0, 1, 48'h0, 48'h0, 1, 1, 1};
    cfg[5] = '{1, 0, 48'h0, 48'h0, 1, 3, 0};
    for (int k = 0; k < NI; k++) begin
      m_p[k] = '0; m_cy[k] = '0; m_pd[k] = 0; m_pbd[k] = 0; m_pdp[k] = 0; m_pbdp[k] = 0;
    end

    // reset priority over CEP, release, re-reset, hold
    drive(1, 1, 48'h1234, 4'h3, 48'h0);
    drive(0, 1, 48'h1234, 4'h3, 48'h0);
    drive(0, 1, 48'h1234, 4'h5, 48'h0);
    drive(1, 1, 48'h1234, 4'h5, 48'h0);
    drive(0, 0, 48'h9999, 4'h9, 48'h0);
    drive(0, 0, 48'hAAAA, 4'hA, 48'h0);
    // pattern / pattern-bar
    drive(0, 1, 48'h1234_5678_9A00, 4'h1, 48'h0);
    drive(0, 1, 48'h0000_0000_00FF, 4'h2, 48'h0);
    // overflow then underflow
    drive(0, 1, 48'h3FFF_FFFF_FFFF, 4'h0, 48'h0);
    drive(0, 1, 48'h4000_0000_0000, 4'h0, 48'h0);
    drive(0, 1, 48'h4000_0000_0000, 4'h0, 48'h0);
    drive(0, 1, 48'hC000_0000_0000, 4'h0, 48'h0);
    drive(0, 1, 48'hBFFF_FFFF_FFFF, 4'h0, 48'h0);
    drive(0, 1, 48'hBFFF_FFFF_FFFF, 4'h0, 48'h0);
    // rounding mask from C
    drive(0, 1, 48'h0000_0000_0020, 4'h0, 48'h000F);
    drive(0, 1, 48'hABCD_0000_0000, 4'h0, 48'h000F);
    // PREG=0 path with CEP low
    drive(0, 0, 48'h55, 4'h7, 48'h000F);
    drive(0, 0, 48'h66, 4'h8, 48'h000F);
    // let the counter wrap at least twice
    for (int n = 0; n < 16; n++) drive(0, 1, rand48(), 4'($urandom()), 48'h000F);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       c = rand48();
        1:       c = 48'h000F;
        2:       c = '1;
        default: c = '0;
      endcase
      case ($urandom_range(0, 7))
        0:       a = rand48();
        1:       a = 48'h3FFF_FFFF_FFFF;
        2:       a = 48'h4000_0000_0000;
        3:       a = 48'hC000_0000_0000;
        4:       a = 48'hBFFF_FFFF_FFFF;
        5:       a = rand48() & c;
        6:       a = 48'($urandom_range(0, 255));
        default: a = {40'hFF_FFFF_FFFF, 8'($urandom())};
      endcase
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), a,
            4'($urandom()), c);
    end
    stim_done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin
    obs_row_t want;
    obs_t     got;
    int       cyc = 0;
    while (!(stim_done && exp_q.size() == 0)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        total++;
        bad++;
        $display("FAIL timeout cyc=%0d queued=%0d required=0", cyc, exp_q.size());
        break;
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        for (int k = 0; k < NI; k++) begin
          got = {p_o[k], pc_o[k], cy_o[k], pd_o[k], pbd_o[k], ov_o[k], un_o[k]};
          total++;
          if (got !== want[k]) begin
            bad++;
            $display("FAIL inst%0d cyc=%0d got p=%h pc=%h cy=%h pd=%b pbd=%b ov=%b un=%b want p=%h pc=%h cy=%h pd=%b pbd=%b ov=%b un=%b",
                     k, cyc, got.p, got.pc, got.cy, got.pd, got.pbd, got.ov, got.un,
                     want[k].p, want[k].pc, want[k].cy, want[k].pd, want[k].pbd,
                     want[k].ov, want[k].un);
          end
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
